// File: rtl/toggle_checker.sv
// Receive-side lock/error checker for a single-bit alternating (0,1,0,1...) pattern.
// Latency: 1 cycle; every output is registered and reflects the sample taken at the previous edge.
// Backpressure: none; en only qualifies samples and the outputs never stall the datapath.
// Optional feature: define TOGGLE_CHK_STICKY_EN to add the sticky lost_lock output.
module toggle_checker #(
  parameter int LOCK_CNT = 4,   // consecutive good transitions to acquire lock (1..255)
  parameter int LOSS_CNT = 3,   // consecutive bad transitions that drop lock (1..255)
  parameter int ERR_W    = 16   // error counter width
) (
  input  logic             clk,
  input  logic             reset,      // synchronous, active-low
  input  logic             en,
  input  logic             din,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
`ifdef TOGGLE_CHK_STICKY_EN
  ,
  output logic             lost_lock
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_SLIP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             prev_q, prev_d;
  logic [7:0]       run_q, run_d;
  logic [7:0]       bad_q, bad_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic [7:0]       run_inc, bad_inc;
  logic             good;

  assign run_inc = run_q + 8'd1;
  assign bad_inc = bad_q + 8'd1;
  assign good    = (din != prev_q);

  // Next-state, run/error counters and error detection for one qualified sample.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    bad_d   = bad_q;
    err_d   = 1'b0;
    if (en) begin
      prev_d = din;
    end
    case (state_q)
      ST_IDLE: begin
        // First sample only primes prev; there is nothing to compare it against yet.
        if (en) begin
          run_d   = 8'd0;
          state_d = ST_HUNT;
        end
      end
      ST_HUNT: begin
        if (en) begin
          if (good) begin
            run_d = run_inc;
            if (run_inc == 8'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
              bad_d   = 8'd0;
            end
          end else begin
            // Unlocked mismatches just restart the hunt; they are not errors.
            run_d = 8'd0;
          end
        end
      end
      ST_LOCKED: begin
        if (en && !good) begin
          err_d = 1'b1;
          bad_d = 8'd1;
          if (LOSS_CNT == 1) begin
            state_d = ST_HUNT;
            run_d   = 8'd0;
          end else begin
            state_d = ST_SLIP;
          end
        end
      end
      ST_SLIP: begin
        if (en) begin
          if (good) begin
            state_d = ST_LOCKED;
            bad_d   = 8'd0;
          end else begin
            err_d = 1'b1;
            bad_d = bad_inc;
            if (bad_inc == 8'(LOSS_CNT)) begin
              state_d = ST_HUNT;
              run_d   = 8'd0;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Lock output follows the next state; error counter saturates and clear wins over the old value.
  always_comb begin
    locked_d = (state_d == ST_LOCKED) || (state_d == ST_SLIP);
    cnt_d    = cnt_q;
    if (clear_err) begin
      cnt_d = err_d ? ERR_W'(1) : '0;
    end else if (err_d && !(&cnt_q)) begin
      cnt_d = cnt_q + ERR_W'(1);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      prev_q      <= 1'b0;
      run_q       <= 8'd0;
      bad_q       <= 8'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      bad_q       <= bad_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = cnt_q;

`ifdef TOGGLE_CHK_STICKY_EN
  logic lost_q, lost_d;

  // Sticky loss flag: set on any locked-to-hunt drop, a same-cycle set beats clear_err.
  always_comb begin
    lost_d = lost_q;
    if (clear_err) begin
      lost_d = 1'b0;
    end
    if (((state_q == ST_LOCKED) || (state_q == ST_SLIP)) && (state_d == ST_HUNT)) begin
      lost_d = 1'b1;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lost_q <= 1'b0;
    end else begin
      lost_q <= lost_d;
    end
  end

  assign lost_lock = lost_q;
`endif

endmodule

// File: tb/tb_toggle_checker.sv
// Bench for toggle_checker: a default instance and a narrow instance (ERR_W=2, LOSS_CNT=1)
// share one stimulus stream; a lock/run-count model predicts every output each cycle,
// and directed checkpoints pin the model with hand-computed literal values.
module tb_toggle_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, din, clr;
  logic lk0, ep0, lk1, ep1;
  logic [15:0] ec0;
  logic [1:0]  ec1;
`ifdef TOGGLE_CHK_STICKY_EN
  logic ll0, ll1;
`endif

  toggle_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) u0 (
    .clk(clk), .reset(rst_n), .en(en), .din(din), .clear_err(clr),
    .locked(lk0), .err_pulse(ep0), .err_count(ec0)
`ifdef TOGGLE_CHK_STICKY_EN
    , .lost_lock(ll0)
`endif
  );

  toggle_checker #(.LOCK_CNT(4), .LOSS_CNT(1), .ERR_W(2)) u1 (
    .clk(clk), .reset(rst_n), .en(en), .din(din), .clear_err(clr),
    .locked(lk1), .err_pulse(ep1), .err_count(ec1)
`ifdef TOGGLE_CHK_STICKY_EN
    , .lost_lock(ll1)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 0;

  // Model: "primed" flag, lock flag, good-run and bad-run counters, integer error count.
  bit m_primed[2], m_prev[2], m_locked[2], m_pulse[2], m_lost[2];
  int m_run[2], m_bad[2], m_cnt[2];

  task automatic model_step(input int k);
    int  lk_n, ls_n, mx;
    bit  err, was_locked, good;
    lk_n = 4;
    ls_n = (k == 0) ? 3 : 1;
    mx   = (k == 0) ? 65535 : 3;
    if (!rst_n) begin
      m_primed[k] = 0; m_prev[k] = 0; m_locked[k] = 0; m_pulse[k] = 0;
      m_lost[k] = 0; m_run[k] = 0; m_bad[k] = 0; m_cnt[k] = 0;
      return;
    end
    err = 0;
    was_locked = m_locked[k];
    if (en) begin
      if (!m_primed[k]) begin
        m_primed[k] = 1;
        m_run[k] = 0;
      end else begin
        good = (din != m_prev[k]);
        if (!m_locked[k]) begin
          if (good) begin
            m_run[k]++;
            if (m_run[k] == lk_n) begin
              m_locked[k] = 1;
              m_bad[k] = 0;
            end
          end else begin
            m_run[k] = 0;
          end
        end else begin
          if (good) begin
            m_bad[k] = 0;
          end else begin
            err = 1;
            m_bad[k]++;
            if (m_bad[k] == ls_n) begin
              m_locked[k] = 0;
              m_run[k] = 0;
            end
          end
        end
      end
      m_prev[k] = din;
    end
    if (clr) m_cnt[k] = 0;
    if (err && m_cnt[k] < mx) m_cnt[k]++;
    m_pulse[k] = err;
    if (clr) m_lost[k] = 0;
    if (was_locked && !m_locked[k]) m_lost[k] = 1;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, half a cycle away from the sampling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("u0.locked",    {31'd0, lk0}, {31'd0, m_locked[0]});
      chk("u0.err_pulse", {31'd0, ep0}, {31'd0, m_pulse[0]});
      chk("u0.err_count", {16'd0, ec0}, m_cnt[0]);
      chk("u1.locked",    {31'd0, lk1}, {31'd0, m_locked[1]});
      chk("u1.err_pulse", {31'd0, ep1}, {31'd0, m_pulse[1]});
      chk("u1.err_count", {30'd0, ec1}, m_cnt[1]);
`ifdef TOGGLE_CHK_STICKY_EN
      chk("u0.lost_lock", {31'd0, ll0}, {31'd0, m_lost[0]});
      chk("u1.lost_lock", {31'd0, ll1}, {31'd0, m_lost[1]});
`endif
    end
  end

  // Apply one cycle of inputs, then return just after the edge that sampled them.
  task automatic step(input bit r, input bit e, input bit d, input bit c);
    rst_n = r; en = e; din = d; clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit last;
    rst_n = 1'b0; en = 1'b0; din = 1'b0; clr = 1'b0;
    step(0, 0, 0, 0);
    // Reset overrides en and clear_err.
    step(0, 1, 1, 1);
    chk_on = 1;
    chk("rst.locked", {31'd0, lk0}, 32'd0);
    chk("rst.err_pulse", {31'd0, ep0}, 32'd0);
    chk("rst.err_count", {16'd0, ec0}, 32'd0);
    chk("rst.u1_count", {30'd0, ec1}, 32'd0);

    // Acquire lock: prime + 4 good samples.
    for (int i = 0; i < 5; i++) begin
      step(1, 1, bit'(i & 1), 0);
      if (i == 3) chk("lock.before5", {31'd0, lk0}, 32'd0);
    end
    chk("lock.after5", {31'd0, lk0}, 32'd1);
    chk("lock.u1", {31'd0, lk1}, 32'd1);
    chk("lock.count0", {16'd0, ec0}, 32'd0);

    // Single repeated bit: one error, u0 slips but stays locked, u1 (LOSS_CNT=1) drops.
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("slip.pulse", {31'd0, ep0}, 32'd1);
    chk("slip.count", {16'd0, ec0}, 32'd1);
    chk("slip.locked", {31'd0, lk0}, 32'd1);
    chk("loss1.locked", {31'd0, lk1}, 32'd0);
    chk("loss1.count", {30'd0, ec1}, 32'd1);
    step(1, 1, 0, 0);
    chk("slip.recover_pulse", {31'd0, ep0}, 32'd0);
    chk("slip.recover_lock", {31'd0, lk0}, 32'd1);

    // din 1,1,1,1: three errors, lock falls with the third.
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
    chk("loss.locked", {31'd0, lk0}, 32'd0);
    chk("loss.pulse", {31'd0, ep0}, 32'd1);
    chk("loss.count", {16'd0, ec0}, 32'd4);
    chk("loss.u1_hunt_noerr", {30'd0, ec1}, 32'd1);
`ifdef TOGGLE_CHK_STICKY_EN
    chk("loss.lost_lock", {31'd0, ll0}, 32'd1);
`endif

    // Five lock-then-error rounds: narrow counter saturates at 3.
    for (int r = 0; r < 5; r++) begin
      step(1, 1, 0, 0); step(1, 1, 1, 0); step(1, 1, 0, 0); step(1, 1, 1, 0);
      step(1, 1, 1, 0);
    end
    chk("sat.u1_count", {30'd0, ec1}, 32'd3);
    chk("sat.u0_count", {16'd0, ec0}, 32'd9);
    chk("sat.u0_locked", {31'd0, lk0}, 32'd1);

    // clear_err together with a counted error leaves 1.
    step(1, 1, 1, 1);
    chk("clr.err_count", {16'd0, ec0}, 32'd1);
    chk("clr.pulse", {31'd0, ep0}, 32'd1);
    chk("clr.u1_count", {30'd0, ec1}, 32'd0);

    // Reset while in SLIP, then full re-lock is needed.
    step(0, 1, 0, 1);
    chk("rslip.locked", {31'd0, lk0}, 32'd0);
    chk("rslip.pulse", {31'd0, ep0}, 32'd0);
    chk("rslip.count", {16'd0, ec0}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, bit'(i & 1), 0);
      if (i == 3) chk("relock.before5", {31'd0, lk0}, 32'd0);
    end
    chk("relock.after5", {31'd0, lk0}, 32'd1);

    // en toggling: idle cycles carry a repeated bit that must be ignored.
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, bit'(i & 1), 0);
      step(1, 0, bit'(i & 1), 0);
    end
    chk("entog.locked", {31'd0, lk0}, 32'd1);
    chk("entog.count", {16'd0, ec0}, 32'd0);

    // Mostly-alternating traffic with occasional slips, gaps, clears and resets.
    last = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bit r, e, d, c;
      r = ($urandom_range(0, 99) != 0);
      e = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 5) == 0) ? last : ~last;
      c = ($urandom_range(0, 19) == 0);
      if (e) last = d;
      step(r, e, d, c);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
